// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the dmem_responder slice.
package dmem_resp_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int BE_W   = 4;
    localparam int CNT_W  = 4;

    // Responder transaction states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between an initiator (master) and dmem_responder (slave).
interface dmem_responder_if;
    import dmem_resp_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_resp_array.sv
// Single-port word storage with per-byte write enables and a registered read.
module dmem_resp_array
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Byte-lane write or full-word registered read on an enabled cycle.
    // NOTE: the storage array has no reset on purpose; clearing it would turn
    // a RAM into a huge flop bank, and its contents must survive rst anyway.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) begin
                        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request, waits WAIT_CYCLES, commits the
// access on the edge entering RESP and holds the response until accepted.
// Optional feature: define DMEM_RESP_MISALIGN_CHECK_EN to reject misaligned
// requests with rsp_err=1.
module dmem_responder
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic              err_q;

    logic              accept;
    logic              commit;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [BE_W-1:0]   c_be;
    logic              range_err;
    logic              misalign_err;
    logic              c_err;
    logic [DATA_W-1:0] arr_rdata;

    assign accept = bus.req_valid && (state_q == IDLE);

    // With zero wait states the commit happens on the accept edge itself, so
    // the live request is used; otherwise the latched copy is.
    assign c_we    = (state_q == IDLE) ? bus.req_we    : we_q;
    assign c_addr  = (state_q == IDLE) ? bus.req_addr  : addr_q;
    assign c_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;
    assign c_be    = (state_q == IDLE) ? bus.req_be    : be_q;

    // Commit on the edge that moves the FSM into RESP (never during reset).
    assign commit = (state_d == RESP) && (state_q != RESP);

    assign range_err = c_addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH_WORDS);
`ifdef DMEM_RESP_MISALIGN_CHECK_EN
    assign misalign_err = (c_addr[1:0] != 2'b00);
`else
    logic unused_byte_offset;
    assign unused_byte_offset = ^c_addr[1:0];
    assign misalign_err = 1'b0;
`endif
    assign c_err = range_err || misalign_err;

    dmem_resp_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .en    (commit && !c_err),
        .we    (c_we),
        .be    (c_be),
        .idx   (c_addr[IDX_W+1:2]),
        .wdata (c_wdata),
        .rdata (arr_rdata)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    // NOTE: state_d gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (rst) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (accept) state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
                WAIT: if (cnt_q == LAST_CNT) state_d = RESP;
                RESP: if (bus.rsp_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Wait-state counter: runs only while in WAIT, zero elsewhere.
    always_ff @(posedge clk) begin
        if (rst || state_q != WAIT) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Capture the request on acceptance so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
        end
    end

    // Error status is decided at commit and held through RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (commit) begin
            err_q <= c_err;
        end
    end

    // Output decode: response fields are zero outside RESP.
    always_comb begin
        bus.req_ready = (state_q == IDLE);
        bus.rsp_valid = (state_q == RESP);
        bus.rsp_err   = (state_q == RESP) && err_q;
        bus.rsp_rdata = '0;
        if (state_q == RESP && !we_q && !err_q) begin
            bus.rsp_rdata = arr_rdata;
        end
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit storage words (power of two, at least 4).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the number of wait states between request accept and response (0..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the initiator presents a request.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 for a store, 0 for a load.
REQ-008 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 The block SHALL have port req_wdata, input, 32 bits: store data.
REQ-010 The block SHALL have port req_be, input, 4 bits: byte enables, bit i for byte lane i.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: a response is present.
REQ-012 The block SHALL have port rsp_ready, input, 1 bit: the initiator accepts the response.
REQ-013 The block SHALL have port rsp_rdata, output, 32 bits: load data; 0 for stores.
REQ-014 The block SHALL have port rsp_err, output, 1 bit: error status for the transaction.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-016 In IDLE, req_ready SHALL be 1; in WAIT and RESP, req_ready SHALL be 0.
REQ-017 A request is accepted when req_valid and req_ready are both 1; on acceptance, we, addr, wdata and be SHALL be latched.
REQ-018 On acceptance, the FSM SHALL go to WAIT with wait counter 0 if WAIT_CYCLES > 0, otherwise to RESP.
REQ-019 In WAIT, the counter SHALL increment every cycle; when it equals WAIT_CYCLES-1, the FSM SHALL go to RESP on the next edge.
REQ-020 The memory access (commit) SHALL occur on the edge entering RESP; the response latency SHALL be 1+WAIT_CYCLES cycles from the accept edge to rsp_valid=1.
REQ-021 A store commit SHALL write only the byte lanes whose req_be bit is 1; a store with be=0 SHALL write nothing and report no error.
REQ-022 A load commit SHALL register the full word at word index addr[31:2] onto rsp_rdata, ignoring be.
REQ-023 If addr[31:2] >= DEPTH_WORDS: no write, rsp_rdata=0, rsp_err=1.
REQ-024 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL be held stable until rsp_ready=1.
REQ-025 When rsp_ready=1 in RESP, the FSM SHALL return to IDLE on that edge; a new request SHALL be accepted no earlier than the following cycle (no back-to-back overlap).
REQ-026 In IDLE and WAIT, rsp_valid SHALL be 0, and rsp_rdata and rsp_err SHALL be 0.
REQ-027 Changes on the req_* inputs after acceptance SHALL have no effect on the transaction in flight.

Reset
REQ-028 While rst=1 at an edge, the next state SHALL be IDLE with counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-029 Reset during WAIT SHALL abort the transaction; a pending store SHALL NOT be committed.
REQ-030 Reset during RESP SHALL drop the response.
REQ-031 Storage contents SHALL NOT be cleared by rst.

Configuration
REQ-032 When the macro DMEM_RESP_MISALIGN_CHECK_EN is defined, a misaligned request SHALL be suppressed (no write, rsp_rdata=0) and SHALL produce rsp_err=1.
REQ-033 A request is misaligned when addr[1:0]!=0, or when addr[0]!=0 and be is a halfword (0011/1100).
REQ-034 When DMEM_RESP_MISALIGN_CHECK_EN is undefined, addr[1:0] SHALL be ignored and only the range error of REQ-023 SHALL exist.

Structure
REQ-035 Package dmem_resp_pkg SHALL hold the FSM state enum (IDLE/WAIT/RESP), DATA_W=32, ADDR_W=32 and BE_W=4.
REQ-036 Storage SHALL be a sub-module dmem_resp_array: single port, synchronous read, per-byte write enable, DEPTH_WORDS deep.
REQ-037 The FSM, wait counter and error logic SHALL reside in dmem_responder.

Verification
REQ-038 Store then load, WAIT_CYCLES=2:
- Stimulus: store addr 0x10, data 0xDEADBEEF, be=1111; then a load of 0x10.
- Response: rsp_valid 3 cycles after each accept; load rsp_rdata=0xDEADBEEF; rsp_err=0.
REQ-039 Byte-enable merge:
- Stimulus: store 0x11223344 at 0x20 with be=1111; then store 0xAABBCCDD with be=0101; then load 0x20.
- Response: load returns 0x11BB33DD.
REQ-040 Response back-pressure:
- Stimulus: hold rsp_ready=0 for 5 cycles in RESP.
- Response: rsp_valid, rsp_rdata and rsp_err stay constant; req_ready stays 0 until the cycle after the rsp_ready handshake.
REQ-041 Out of range and misalignment, DEPTH_WORDS=256:
- Stimulus: load 0x400.
- Response: rsp_err=1, rsp_rdata=0.
- With the macro defined: store to 0x22, be=1111, gives rsp_err=1 and memory unchanged.
REQ-042 Reset during WAIT:
- Stimulus: assert rst during WAIT of a store of 0x5 to 0x8; then load 0x8.
- Response: load returns the prior contents of 0x8; outputs are at reset values after the rst edge.
REQ-043 WAIT_CYCLES=0:
- Stimulus: issue a load.
- Response: rsp_valid=1 one cycle after the accept.
